// File: rtl/seq_detector_param_if.sv
// Bundle of the serial stream, configuration and result signals of seq_detector_param.
// The bench drives it through the master modport. The detector uses the slave modport.
interface seq_detector_param_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
);
  logic                 in_valid;
  logic                 in_bit;
  logic                 cfg_load;
  logic [PATTERN_W-1:0] cfg_pattern;
  logic                 cfg_overlap;
  logic                 cnt_clr;
  logic                 match;
  logic [CNT_W-1:0]     match_count;
  logic                 busy;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    input  match, match_count, busy
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    output match, match_count, busy
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with a registered match pulse and an overlap mode.
// Defining SEQDET_COUNT_EN adds the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param #(
  parameter int                   PATTERN_W       = 4,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1011,
  parameter logic                 DEFAULT_OVERLAP = 1'b1,
  parameter int                   CNT_W           = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_detector_param_if.slave bus
);
  localparam int             FW   = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(PATTERN_W);

  typedef enum logic {FILLING, ARMED} state_t;

  state_t               state, state_nxt;
  logic [PATTERN_W-1:0] hist, hist_nxt, hist_sh, pat_q;
  logic [FW-1:0]        fill, fill_nxt, fill_inc;
  logic                 ovl_q;
  logic                 vld_p0;
  logic                 hit;
  logic                 match_p1, busy_p1;

  // stage p0: a load in the same cycle discards the presented bit
  assign vld_p0   = bus.in_valid && !bus.cfg_load;
  assign hist_sh  = {hist[PATTERN_W-2:0], bus.in_bit};
  assign fill_inc = (state == ARMED) ? FULL : fill + FW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILLING;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = FILLING;
    if (fill_nxt == FULL) state_nxt = ARMED;
  end

  // A zero-filled history never matches until PATTERN_W real bits have arrived.
  always_comb begin
    hit = 1'b0;
    if (vld_p0 && (hist_sh == pat_q) && (fill_inc == FULL)) hit = 1'b1;
  end

  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    if (bus.cfg_load) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (vld_p0) begin
      if (hit && !ovl_q) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end else begin
        hist_nxt = hist_sh;
        fill_nxt = fill_inc;
      end
    end
  end

  // stage p1: registered match and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      fill     <= '0;
      pat_q    <= DEFAULT_PATTERN;
      ovl_q    <= DEFAULT_OVERLAP;
      match_p1 <= 1'b0;
      busy_p1  <= 1'b0;
    end else begin
      hist     <= hist_nxt;
      fill     <= fill_nxt;
      match_p1 <= hit;
      busy_p1  <= (fill_nxt != '0);
      if (bus.cfg_load) begin
        pat_q <= bus.cfg_pattern;
        ovl_q <= bus.cfg_overlap;
      end
    end
  end

  assign bus.match = match_p1;
  assign bus.busy  = busy_p1;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A clear coinciding with a match wins and the increment is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt_q <= '0;
    else if (bus.cnt_clr) cnt_q <= '0;
    else if (match_p1)    cnt_q <= sat_inc(cnt_q);
  end

  assign bus.match_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr  = bus.cnt_clr;
  assign bus.match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances (3-, 4- and 2-bit patterns) checked cycle by cycle
// against per-instance queues of expected match values plus a saturating count model.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  seq_detector_param_if #(.PATTERN_W(3), .CNT_W(8)) b3 ();
  seq_detector_param_if #(.PATTERN_W(4), .CNT_W(8)) b4 ();
  seq_detector_param_if #(.PATTERN_W(2), .CNT_W(2)) b2 ();

  seq_detector_param #(.PATTERN_W(3), .DEFAULT_PATTERN(3'b101), .DEFAULT_OVERLAP(1'b1), .CNT_W(8))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  seq_detector_param #(.PATTERN_W(4), .DEFAULT_PATTERN(4'b1011), .DEFAULT_OVERLAP(1'b1), .CNT_W(8))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  seq_detector_param #(.PATTERN_W(2), .DEFAULT_PATTERN(2'b11), .DEFAULT_OVERLAP(1'b1), .CNT_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;

  logic       q3[$], q4[$], q2[$];
  logic       cm3, cm4, cm2;
  logic [7:0] ecnt3, ecnt4;
  logic [1:0] ecnt2;

  function automatic logic [31:0] cexp(input logic [31:0] v);
    return CNT_EN ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    b3.in_valid = 1'b0; b3.cfg_load = 1'b0; b3.cnt_clr = 1'b0;
    b4.in_valid = 1'b0; b4.cfg_load = 1'b0; b4.cnt_clr = 1'b0;
    b2.in_valid = 1'b0; b2.cfg_load = 1'b0; b2.cnt_clr = 1'b0;
  endtask

  // One clock: queue the expected match of each instance, advance the count models, compare after the edge.
  task automatic cycle(input logic e3, input logic e4, input logic e2);
    q3.push_back(e3); q4.push_back(e4); q2.push_back(e2);
    if (b3.cnt_clr) ecnt3 = 8'd0; else if (cm3 && ecnt3 != 8'hff) ecnt3 = ecnt3 + 8'd1;
    if (b4.cnt_clr) ecnt4 = 8'd0; else if (cm4 && ecnt4 != 8'hff) ecnt4 = ecnt4 + 8'd1;
    if (b2.cnt_clr) ecnt2 = 2'd0; else if (cm2 && ecnt2 != 2'd3)  ecnt2 = ecnt2 + 2'd1;
    @(posedge clk); #1;
    cm3 = q3.pop_front(); chk("match3", b3.match, cm3);
    cm4 = q4.pop_front(); chk("match4", b4.match, cm4);
    cm2 = q2.pop_front(); chk("match2", b2.match, cm2);
    idle_inputs();
  endtask

  task automatic feed3(input logic b, input logic e);
    b3.in_valid = 1'b1; b3.in_bit = b; cycle(e, 1'b0, 1'b0);
  endtask
  task automatic feed4(input logic b, input logic e);
    b4.in_valid = 1'b1; b4.in_bit = b; cycle(1'b0, e, 1'b0);
  endtask
  task automatic feed2(input logic b, input logic e);
    b2.in_valid = 1'b1; b2.in_bit = b; cycle(1'b0, 1'b0, e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    b3.in_bit = 1'b0; b3.cfg_pattern = 3'b000;  b3.cfg_overlap = 1'b0;
    b4.in_bit = 1'b0; b4.cfg_pattern = 4'b0000; b4.cfg_overlap = 1'b0;
    b2.in_bit = 1'b0; b2.cfg_pattern = 2'b00;   b2.cfg_overlap = 1'b0;
    idle_inputs();
    cm3 = 1'b0; cm4 = 1'b0; cm2 = 1'b0;
    ecnt3 = '0; ecnt4 = '0; ecnt2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match3", b3.match, 0);
    chk("rst_busy3", b3.busy, 0);
    chk("rst_busy4", b4.busy, 0);
    chk("rst_busy2", b2.busy, 0);
    chk("rst_cnt3", b3.match_count, 0);
    rst_n = 1'b1;

    // Overlap, pattern 101, stream 1,0,1,0,1
    feed3(1, 0); feed3(0, 0); feed3(1, 1); feed3(0, 0); feed3(1, 1);
    idle(1);
    chk("cnt_ovl3", b3.match_count, cexp(2));
    chk("cnt_ovl3_model", b3.match_count, cexp(ecnt3));

    // Clear, then non-overlap on the same stream plus 1,0,1
    b3.cnt_clr = 1'b1; idle(1);
    chk("cnt_clr3", b3.match_count, 0);
    b3.cfg_load = 1'b1; b3.cfg_pattern = 3'b101; b3.cfg_overlap = 1'b0; idle(1);
    feed3(1, 0); feed3(0, 0); feed3(1, 1);
    chk("busy_novl_hit3", b3.busy, 0);
    feed3(0, 0); feed3(1, 0);
    chk("busy_novl_part3", b3.busy, 1);
    feed3(1, 0); feed3(0, 0); feed3(1, 1);
    idle(1);
    chk("cnt_novl3", b3.match_count, cexp(2));

    // Valid gaps of 3 idle cycles between 1,0,1
    b3.cfg_load = 1'b1; b3.cfg_pattern = 3'b101; b3.cfg_overlap = 1'b1; idle(1);
    feed3(1, 0); idle(3);
    chk("busy_gap1_3", b3.busy, 1);
    feed3(0, 0); idle(3);
    chk("busy_gap2_3", b3.busy, 1);
    feed3(1, 1); idle(1);
    chk("cnt_gap3", b3.match_count, cexp(3));

    // All-zero pattern, non-overlap: three zeros must not match before fill is complete
    b4.cfg_load = 1'b1; b4.cfg_pattern = 4'b0000; b4.cfg_overlap = 1'b0; idle(1);
    feed4(0, 0); feed4(0, 0); feed4(0, 0);
    chk("busy_part4", b4.busy, 1);

    // Asynchronous reset mid-sequence
    rst_n = 1'b0;
    #1;
    chk("arst_busy4", b4.busy, 0);
    chk("arst_match4", b4.match, 0);
    chk("arst_cnt3", b3.match_count, 0);
    cm3 = 1'b0; cm4 = 1'b0; cm2 = 1'b0;
    ecnt3 = '0; ecnt4 = '0; ecnt2 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Default 1011 restored; fill restarted so a lone 1 gives nothing
    feed4(1, 0);
    feed4(1, 0); feed4(0, 0); feed4(1, 0); feed4(1, 1);
    // Default overlap restored: suffix "1" plus 0,1,1 matches again
    feed4(0, 0); feed4(1, 0); feed4(1, 1);
    idle(1);
    chk("cnt_rst4", b4.match_count, cexp(2));

    // Load collides with a valid bit: the bit is discarded
    b4.cfg_load = 1'b1; b4.cfg_pattern = 4'b0110; b4.cfg_overlap = 1'b1;
    b4.in_valid = 1'b1; b4.in_bit = 1'b1;
    cycle(0, 0, 0);
    chk("busy_load4", b4.busy, 0);
    feed4(0, 0); feed4(1, 0); feed4(1, 0); feed4(0, 1);

    // Saturation with a 2-bit counter, pattern 11, overlap
    feed2(1, 0);
    for (int i = 0; i < 5; i++) feed2(1, 1);
    idle(1);
    chk("cnt_sat2", b2.match_count, cexp(3));
    chk("cnt_sat2_model", b2.match_count, cexp(ecnt2));
    feed2(1, 1);
    b2.cnt_clr = 1'b1; idle(1);
    chk("cnt_clr_coll2", b2.match_count, 0);
    idle(1);
    chk("cnt_after_clr2", b2.match_count, 0);
    feed2(1, 1); idle(1);
    chk("cnt_restart2", b2.match_count, cexp(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector for the FSM library. It compares a 1-bit serial stream, qualified by a valid strobe, against a PATTERN_W-bit pattern that software can load at runtime. Each completed occurrence produces a registered one-cycle match pulse. The detector runs in overlapping or non-overlapping mode and keeps a saturating match counter. It replaces the fixed-pattern, fixed-mode detectors at the serial front end of the examples.

## Interface
- PATTERN_W, 4: pattern length in bits; legal range 2..16.
- DEFAULT_PATTERN, 4'b1011: pattern value after reset; PATTERN_W bits wide.
- DEFAULT_OVERLAP, 1: overlap mode after reset (1 = overlapping).
- CNT_W, 8: match counter width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies in_bit; when low, the cycle is ignored.
- in_bit  in  1  serial data; the first-received bit aligns with the pattern MSB.
- cfg_load  in  1  one-cycle strobe that loads cfg_pattern and cfg_overlap.
- cfg_pattern  in  PATTERN_W  new pattern value.
- cfg_overlap  in  1  new overlap mode.
- cnt_clr  in  1  synchronous clear of match_count.
- match  out  1  registered pulse, high for one cycle per detected occurrence.
- match_count  out  CNT_W  saturating count of matches.
- busy  out  1  high while fill > 0 (partial history held).

## Operation
- Internal state: hist (PATTERN_W-bit shift register); fill (0..PATTERN_W, width clog2(PATTERN_W+1)); pat_q; ovl_q.
- Two-state control FSM:
  - FILLING: fill < PATTERN_W.
  - ARMED: fill == PATTERN_W.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist <= {hist[PATTERN_W-2:0], in_bit}.
  - fill <= min(fill+1, PATTERN_W).
- Hit: the post-shift hist equals pat_q and the post-increment fill equals PATTERN_W.
- On a hit, match <= 1 on the next edge; otherwise match <= 0.
- After a hit:
  - Overlap mode (ovl_q=1): hist and fill are retained, so a suffix of the match can start the next match.
  - Non-overlap mode (ovl_q=0): fill <= 0 and hist <= 0 on the same edge; the next match needs PATTERN_W fresh bits.
- in_valid=0: hist and fill hold; match <= 0. Gaps never break a partial sequence.
- cfg_load=1:
  - pat_q <= cfg_pattern and ovl_q <= cfg_overlap.
  - hist and fill clear to 0 and match <= 0.
  - Any bit presented in the same cycle is discarded; load wins over in_valid.
- match_count:
  - Increments on each cycle where match is high; saturates at 2^CNT_W-1.
  - cnt_clr clears it to 0. If cnt_clr and an increment coincide, the result is 0 and the increment is lost.
  - cfg_load does not affect match_count.
- Reset (rst_n=0, asynchronous, at any time including mid-sequence):
  - hist=0, fill=0, match=0, match_count=0, busy=0.
  - pat_q=DEFAULT_PATTERN, ovl_q=DEFAULT_OVERLAP.
  - Operation resumes on the first rising edge after rst_n deasserts.
- All-zero pattern: matching still requires fill == PATTERN_W, so a reset history never produces a false match.

## Timing
- Latency: match is high in cycle N+1 when the completing bit is accepted in cycle N. The output is registered, never combinational from in_bit.
- Back-to-back overlap matches with pattern 1111: match is high on consecutive cycles.
- busy is registered and follows fill with the same one-edge delay.
- A configuration change takes effect for bits accepted from the cycle after cfg_load.
- Throughput: one bit per clock, with no stall.

## Configuration
- SEQDET_COUNT_EN defined: match_count and cnt_clr are implemented as specified above.
- SEQDET_COUNT_EN undefined:
  - The counter logic is removed.
  - match_count is tied to 0.
  - cnt_clr is ignored.
  - match, busy and the FSM are unchanged.

## Test plan
- Overlap, PATTERN_W=3, pattern 101, stream 1,0,1,0,1 with continuous valid -> match pulses after bit 3 and after bit 5; match_count=2.
- Non-overlap, same pattern and stream -> single match after bit 3; bits 4-5 (0,1) give none; match_count=1; a further 1,0,1 -> second match.
- Valid gaps: bits 1,0,1 of pattern 101 spaced with 3 idle cycles each -> exactly one match, one cycle after the last accepted bit; busy high across the gaps.
- Reset mid-sequence: pattern 1011, feed 1,0,1, pulse rst_n low, then feed 1 -> no match; then feed 1,0,1,1 -> match; pat_q back at DEFAULT_PATTERN after reset.
- Load collision: cfg_load with pattern 0110 and in_valid=1 in the same cycle -> bit discarded and fill=0; then 0,1,1,0 -> match one cycle after the fourth bit.
- Saturation (CNT_W=2, pattern 11, overlap) -> feed 6 ones -> 5 matches, match_count stops at 3; cnt_clr coincident with a match -> match_count=0.
